// File: rtl/simple_counter_pkg.sv
// Shared types and helpers for the simple_counter block: count-width function and per-cycle op encoding.
package simple_counter_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2
  } op_e;

  // A single-state counter still needs one bit to exist, hence the floor of 1.
  function automatic int unsigned count_width(input int unsigned max_count);
    int unsigned w;
    w = $clog2(max_count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// One-bit rising-edge detector: pulses rise_out in the same cycle sig_in goes high after being low.
// History clears on synchronous active-low reset, so a level held through reset release reads as a new edge.
module rising_edge_detect (
  input  logic clk_in,
  input  logic rst_in,
  input  logic sig_in,
  output logic rise_out
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = sig_in;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_out = sig_in & ~prev_q;

endmodule

// File: rtl/simple_counter.sv
// Edge-triggered up/down counter over 0..MAX_COUNT-1; count registered one edge after an input rises.
// Saturates at the ends by default; define SIMPLE_COUNTER_WRAP_EN to wrap around instead.
module simple_counter
  import simple_counter_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 16,
  parameter int unsigned START_VAL = 15,
  localparam int unsigned CW = count_width(MAX_COUNT)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          add_evt_in,
  input  logic          sub_evt_in,
  output logic [CW-1:0] count_out,
  output logic          at_max_out,
  output logic          at_min_out
);

  if (MAX_COUNT < 2 || START_VAL > MAX_COUNT - 1) begin : g_bad_params
    $fatal(1, "simple_counter: need MAX_COUNT >= 2 and START_VAL <= MAX_COUNT-1");
  end

  localparam logic [CW:0]   MAX_V   = (CW + 1)'(MAX_COUNT - 1);
  localparam logic [CW-1:0] START_V = CW'(START_VAL);

  logic add_rise;
  logic sub_rise;

  rising_edge_detect u_add_edge (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .sig_in   (add_evt_in),
    .rise_out (add_rise)
  );

  rising_edge_detect u_sub_edge (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .sig_in   (sub_evt_in),
    .rise_out (sub_rise)
  );

  op_e op;

  always_comb begin
    op = OP_HOLD;
    if (add_rise && !sub_rise) begin
      op = OP_UP;
    end else if (sub_rise && !add_rise) begin
      op = OP_DOWN;
    end
  end

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW:0]   count_ext;
  logic [CW:0]   count_next_ext;
  logic          unused_next_msb;

  // Extra headroom bit keeps +1 at the top from aliasing before the range check.
  always_comb begin
    count_ext      = {1'b0, count_q};
    count_next_ext = count_ext;
    case (op)
      OP_UP: begin
        if (count_ext == MAX_V) begin
`ifdef SIMPLE_COUNTER_WRAP_EN
          count_next_ext = '0;
`else
          count_next_ext = MAX_V;
`endif
        end else begin
          count_next_ext = count_ext + (CW + 1)'(1);
        end
      end
      OP_DOWN: begin
        if (count_ext == '0) begin
`ifdef SIMPLE_COUNTER_WRAP_EN
          count_next_ext = MAX_V;
`else
          count_next_ext = '0;
`endif
        end else begin
          count_next_ext = count_ext - (CW + 1)'(1);
        end
      end
      default: begin
        count_next_ext = count_ext;
      end
    endcase
    count_d = count_next_ext[CW-1:0];
  end

  assign unused_next_msb = count_next_ext[CW];

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      count_q <= START_V;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out  = count_q;
  assign at_max_out = ({1'b0, count_q} == MAX_V);
  assign at_min_out = (count_q == '0);

endmodule

// File: tb/tb_simple_counter.sv
// Bench for simple_counter: directed scenarios then random events, all checked against an event-level model.
module tb_simple_counter;

  localparam int MAX_COUNT = 16;
  localparam int START_VAL = 15;
  localparam int CW        = 4;
`ifdef SIMPLE_COUNTER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          add_evt_in = 1'b0;
  logic          sub_evt_in = 1'b0;
  logic [CW-1:0] count_out;
  logic          at_max_out;
  logic          at_min_out;

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt    = START_VAL;
  bit m_prev_a = 1'b0;
  bit m_prev_s = 1'b0;

  simple_counter #(
    .MAX_COUNT (MAX_COUNT),
    .START_VAL (START_VAL)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .add_evt_in (add_evt_in),
    .sub_evt_in (sub_evt_in),
    .count_out  (count_out),
    .at_max_out (at_max_out),
    .at_min_out (at_min_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model thinks in events: a level that was low last edge and is high now is one request.
  task automatic model_edge(input bit a, input bit s, input bit rst_n);
    bit ea;
    bit es;
    if (!rst_n) begin
      m_cnt    = START_VAL;
      m_prev_a = 1'b0;
      m_prev_s = 1'b0;
    end else begin
      ea = a && !m_prev_a;
      es = s && !m_prev_s;
      if (ea && !es) begin
        if (m_cnt == MAX_COUNT - 1) m_cnt = WRAP ? 0 : m_cnt;
        else                        m_cnt = m_cnt + 1;
      end else if (es && !ea) begin
        if (m_cnt == 0) m_cnt = WRAP ? MAX_COUNT - 1 : 0;
        else            m_cnt = m_cnt - 1;
      end
      m_prev_a = a;
      m_prev_s = s;
    end
  endtask

  task automatic step(input bit a, input bit s, input bit rst_n, input string tag);
    add_evt_in = a;
    sub_evt_in = s;
    rst_in     = rst_n;
    @(posedge clk_in);
    model_edge(a, s, rst_n);
    #1;
    chk({tag, "_count"}, 32'(count_out), 32'(m_cnt));
    chk({tag, "_at_max"}, 32'(at_max_out), 32'(m_cnt == MAX_COUNT - 1));
    chk({tag, "_at_min"}, 32'(at_min_out), 32'(m_cnt == 0));
  endtask

  task automatic pulse_add(input string tag);
    step(1'b1, 1'b0, 1'b1, tag);
    step(1'b0, 1'b0, 1'b1, tag);
  endtask

  task automatic pulse_sub(input string tag);
    step(1'b0, 1'b1, 1'b1, tag);
    step(1'b0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    #1;
    step(1'b0, 1'b0, 1'b0, "reset");
    step(1'b0, 1'b0, 1'b0, "reset");
    chk("reset_const_count", 32'(count_out), 32'd15);
    chk("reset_const_at_max", 32'(at_max_out), 32'd1);
    chk("reset_const_at_min", 32'(at_min_out), 32'd0);
    step(1'b0, 1'b0, 1'b1, "release");

`ifndef SIMPLE_COUNTER_WRAP_EN
    for (int i = 0; i < 5; i++) begin
      pulse_add("sat_top");
      chk("sat_top_const", 32'(count_out), 32'd15);
      chk("sat_top_flag", 32'(at_max_out), 32'd1);
    end
`endif

    for (int i = 0; i < 5; i++) pulse_sub("sub5");
    chk("sub5_const", 32'(count_out), 32'd10);
    for (int i = 0; i < 3; i++) pulse_sub("sub3");
    chk("sub3_const", 32'(count_out), 32'd7);

    for (int i = 0; i < 16; i++) begin
      pulse_sub("sub16");
`ifndef SIMPLE_COUNTER_WRAP_EN
      chk("sub16_const", 32'(count_out), (i < 6) ? 32'(6 - i) : 32'd0);
`endif
    end
`ifndef SIMPLE_COUNTER_WRAP_EN
    chk("sat_bottom_flag", 32'(at_min_out), 32'd1);
`endif
    for (int i = 0; i < 16; i++) pulse_add("add16");
`ifndef SIMPLE_COUNTER_WRAP_EN
    chk("add16_const", 32'(count_out), 32'd15);
    for (int i = 0; i < 8; i++) pulse_sub("to7");
    chk("to7_const", 32'(count_out), 32'd7);
    step(1'b1, 1'b1, 1'b1, "both");
    chk("both_const", 32'(count_out), 32'd7);
    step(1'b0, 1'b0, 1'b1, "both_rel");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, "held_add");
    chk("held_add_const", 32'(count_out), 32'd8);
    step(1'b0, 1'b0, 1'b1, "held_rel");
    for (int i = 0; i < 5; i++) pulse_sub("to3");
    chk("to3_const", 32'(count_out), 32'd3);
    step(1'b1, 1'b0, 1'b0, "mid_reset");
    chk("mid_reset_const", 32'(count_out), 32'd15);
    step(1'b1, 1'b0, 1'b1, "post_reset_held");
    chk("post_reset_const", 32'(count_out), 32'd15);
    step(1'b1, 1'b0, 1'b1, "post_reset_held2");
    step(1'b0, 1'b0, 1'b1, "post_reset_rel");
`else
    step(1'b0, 1'b0, 1'b0, "wrap_reset");
    step(1'b0, 1'b0, 1'b1, "wrap_release");
    pulse_add("wrap_up");
    chk("wrap_up_const", 32'(count_out), 32'd0);
    chk("wrap_up_min", 32'(at_min_out), 32'd1);
    pulse_sub("wrap_down");
    chk("wrap_down_const", 32'(count_out), 32'd15);
    chk("wrap_down_max", 32'(at_max_out), 32'd1);
`endif

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) != 0), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_counter.md
SIMPLE_COUNTER -- requirements
Module: simple_counter

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 16: number of count states; the legal range is 0..MAX_COUNT-1.
REQ-002 SHALL have parameter START_VAL, default 15: count value loaded at reset.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port add_evt_in, input, 1 bit: increment event request.
REQ-006 SHALL have port sub_evt_in, input, 1 bit: decrement event request.
REQ-007 SHALL have port count_out, output, CW = max(1, $clog2(MAX_COUNT)) bits: current count, unsigned; 4 bits at the defaults.
REQ-008 SHALL have port at_max_out, output, 1 bit: high while count_out == MAX_COUNT-1.
REQ-009 SHALL have port at_min_out, output, 1 bit: high while count_out == 0.

Function
REQ-010 SHALL treat each input as an event only on a rising edge: sampled high this cycle and low the previous cycle. A held-high input counts once.
REQ-011 SHALL update count_out on the same clock edge where the rising edge is detected (one-cycle latency from the input to the registered output).
REQ-012 SHALL increment by 1 on an add-only event and decrement by 1 on a sub-only event.
REQ-013 SHALL leave the count unchanged when add and sub events occur in the same cycle.
REQ-014 SHALL saturate by default: an add event at MAX_COUNT-1 holds the value, and a sub event at 0 holds 0.
REQ-015 SHALL drive at_max_out and at_min_out combinationally from the count register, with no extra latency.
REQ-016 SHALL perform all arithmetic at CW+1 bits internally; count_out never carries an out-of-range value.
REQ-017 SHALL reject START_VAL > MAX_COUNT-1 or MAX_COUNT < 2 at elaboration with a fatal error.

Reset
REQ-018 SHALL, while rst_in == 0 at a clock edge, load count_out = START_VAL and clear both edge-history registers to 0.
REQ-019 SHALL give reset priority over any simultaneous event; events during reset are discarded.
REQ-020 SHALL count an input that is still high on the first cycle after reset release as one rising edge.
REQ-021 SHALL reset at_max_out/at_min_out consistently with START_VAL (1/0 at the defaults).

Configuration
REQ-022 SHALL provide macro SIMPLE_COUNTER_WRAP_EN: when defined, the count wraps (MAX_COUNT-1 + add -> 0, 0 + sub -> MAX_COUNT-1); when undefined, it saturates per REQ-014.
REQ-023 SHALL keep at_max_out/at_min_out behaviour identical in both configurations.

Structure
REQ-024 SHALL place shared items in package simple_counter_pkg: the count-width function and the up/down/hold op enum.
REQ-025 SHALL implement edge detection in sub-module rising_edge_detect, with one instance per event input and the same clock and reset.
REQ-026 SHALL keep all remaining logic (op decode, saturate/wrap, flags) in simple_counter itself.

Verification
REQ-027 SHALL cover: reset with defaults, then 5 add pulses -> count_out stays 15 and at_max_out = 1 throughout.
REQ-028 SHALL cover: from 15, 5 sub pulses -> 10, then 3 sub pulses -> 7.
REQ-029 SHALL cover: from 7, 16 sub pulses -> reaches 0 after 7 pulses and holds 0 with at_min_out = 1; then 16 add pulses -> reaches 15 and holds.
REQ-030 SHALL cover: add and sub rising together at count 7 -> stays 7; add held high for 10 cycles -> +1 only.
REQ-031 SHALL cover: reset asserted mid-sequence at count 3 with add high -> count_out = 15 on the next edge; after release, the held add does not increment at 15 (saturated).
REQ-032 SHALL cover, with SIMPLE_COUNTER_WRAP_EN defined: from 15, one add -> 0; from 0, one sub -> 15.
